// File: rtl/prog_ctr_seq.sv
// rtl/prog_ctr_seq.sv - program-counter sequencer with start/done run handshake
//
// Purpose:
//    Drives the registered fetch address of a combinational instruction ROM.
//    A run starts at START_ADDR when start is seen in IDLE and ends when the
//    decoder flags halt, after which the sequencer parks in DONE until start
//    is released. Next-PC priority while running:
//    halt > stall > ret > call > jump > increment.
//
// Configuration macro:
//    PROG_CTR_LINK_EN - when defined, builds an RS_DEPTH-entry circular return
//    stack so call/ret behave as subroutine call/return. When undefined, call
//    acts as jump and ret simply lets the PC increment.
//
// Ports:
//    clk          - rising-edge clock
//    reset        - synchronous, active-high
//    start        - run request, level-held by the requester
//    done         - high while in DONE
//    halt         - decoded halt in the current instruction
//    stall        - hold the PC this cycle
//    jump         - load target into the PC
//    call         - subroutine call to target
//    ret          - return from subroutine
//    target       - absolute next address for jump/call
//    prog_ctr_out - registered ROM address
//    fetch_valid  - instruction at prog_ctr_out executes this cycle
//    cycle_ct     - saturating count of RUN cycles of the current/last run

module prog_ctr_seq #(
   parameter int unsigned D          = 12,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned RS_DEPTH   = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic         done,
   input  logic         halt,
   input  logic         stall,
   input  logic         jump,
   input  logic         call,
   input  logic         ret,
   input  logic [D-1:0] target,
   output logic [D-1:0] prog_ctr_out,
   output logic         fetch_valid,
   output logic [15:0]  cycle_ct
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [D-1:0] START_PC = D'(START_ADDR);

   // The return stack needs at least one entry when it is built.
   if (RS_DEPTH < 1) begin : g_bad_rs_depth
      $error("prog_ctr_seq: RS_DEPTH must be at least 1");
   end

   state_t       state, state_n;
   logic [D-1:0] pc_n;
   logic [15:0]  cyc_n;
   logic [D-1:0] pc_inc;

   // Natural D-bit overflow gives the required wrap from 2**D-1 to 0.
   assign pc_inc = prog_ctr_out + {{(D-1){1'b0}}, 1'b1};

`ifdef PROG_CTR_LINK_EN
   localparam int SP_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
   localparam int CT_W = $clog2(RS_DEPTH + 1);

   logic [D-1:0]    rs_mem [RS_DEPTH];
   logic [SP_W-1:0] rs_sp;       // next slot to write
   logic [CT_W-1:0] rs_ct;       // live entries, capped at RS_DEPTH
   logic [SP_W-1:0] rs_top;      // slot holding the most recent push
   logic [SP_W-1:0] rs_sp_inc;
   logic            rs_empty;
   logic            rs_full;
   logic            rs_push;
   logic            rs_pop;
   logic            rs_clr;

   assign rs_top    = (rs_sp == '0) ? SP_W'(RS_DEPTH - 1) : rs_sp - SP_W'(1);
   assign rs_sp_inc = (rs_sp == SP_W'(RS_DEPTH - 1)) ? '0 : rs_sp + SP_W'(1);
   assign rs_empty  = (rs_ct == '0);
   assign rs_full   = (rs_ct == CT_W'(RS_DEPTH));

   // Circular stack: a push while full overwrites the oldest entry simply
   // because the write pointer has wrapped onto it; the count stays capped.
   always_ff @(posedge clk) begin
      if (reset || rs_clr) begin
         rs_sp <= '0;
         rs_ct <= '0;
      end else if (rs_push) begin
         rs_mem[rs_sp] <= pc_inc;
         rs_sp         <= rs_sp_inc;
         if (!rs_full) rs_ct <= rs_ct + CT_W'(1);
      end else if (rs_pop) begin
         rs_sp <= rs_top;
         rs_ct <= rs_ct - CT_W'(1);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         prog_ctr_out <= START_PC;
         cycle_ct     <= '0;
      end else begin
         state        <= state_n;
         prog_ctr_out <= pc_n;
         cycle_ct     <= cyc_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = prog_ctr_out;
      cyc_n   = cycle_ct;
`ifdef PROG_CTR_LINK_EN
      rs_push = 1'b0;
      rs_pop  = 1'b0;
      rs_clr  = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_RUN;
               pc_n    = START_PC;
               cyc_n   = '0;
`ifdef PROG_CTR_LINK_EN
               rs_clr  = 1'b1;
`endif
            end
         end
         S_RUN: begin
            // Counts every RUN cycle, stalled and halting ones included.
            if (cycle_ct != 16'hFFFF) cyc_n = cycle_ct + 16'd1;
            if (halt) begin
               state_n = S_DONE;
            end else if (stall) begin
               pc_n = prog_ctr_out;
            end else if (ret) begin
`ifdef PROG_CTR_LINK_EN
               // Returning with nothing to return to ends the program.
               if (rs_empty) begin
                  state_n = S_DONE;
               end else begin
                  pc_n   = rs_mem[rs_top];
                  rs_pop = 1'b1;
               end
`else
               pc_n = pc_inc;
`endif
            end else if (call) begin
               pc_n = target;
`ifdef PROG_CTR_LINK_EN
               rs_push = 1'b1;
`endif
            end else if (jump) begin
               pc_n = target;
            end else begin
               pc_n = pc_inc;
            end
         end
         S_DONE: begin
            // A start that is still held must be released before a rerun.
            if (!start) state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign done        = (state == S_DONE);
   assign fetch_valid = (state == S_RUN);

endmodule

// File: tb/tb_prog_ctr_seq.sv
// tb/tb_prog_ctr_seq.sv - directed self-checking bench for prog_ctr_seq
//
// Purpose:
//    Drives directed vectors into prog_ctr_seq and compares against
//    hand-computed values. Inputs change and outputs are sampled on the
//    falling clock edge. Link-stack scenarios are built only when
//    PROG_CTR_LINK_EN is defined.
//
// Ports: none (top-level bench).

module tb_prog_ctr_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic        done;
   logic        halt;
   logic        stall;
   logic        jump;
   logic        call;
   logic        ret;
   logic [11:0] target;
   logic [11:0] prog_ctr_out;
   logic        fetch_valid;
   logic [15:0] cycle_ct;

   int total;
   int bad;

   prog_ctr_seq #(.D(12), .START_ADDR(0), .RS_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .done         (done),
      .halt         (halt),
      .stall        (stall),
      .jump         (jump),
      .call         (call),
      .ret          (ret),
      .target       (target),
      .prog_ctr_out (prog_ctr_out),
      .fetch_valid  (fetch_valid),
      .cycle_ct     (cycle_ct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr_ctl;
      halt = 0; stall = 0; jump = 0; call = 0; ret = 0; target = '0;
   endtask

   // IDLE -> RUN; returns at the falling edge of the first RUN cycle with start dropped.
   task automatic start_run;
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   // From DONE with start low, step one cycle into IDLE.
   task automatic finish_run(input string tag);
      start = 0;
      clr_ctl();
      @(negedge clk);
      total++;
      if (done !== 1'b0 || fetch_valid !== 1'b0) begin
         bad++; $display("FAIL %s_to_idle done=%b fv=%b exp done=0 fv=0", tag, done, fetch_valid);
      end
   endtask

   task automatic test_reset;
      reset = 1; start = 0; clr_ctl();
      repeat (2) @(negedge clk);
      reset = 0;
      total++;
      if (prog_ctr_out !== 12'h000 || done !== 1'b0 || fetch_valid !== 1'b0 || cycle_ct !== 16'd0) begin
         bad++; $display("FAIL reset_state pc=%h done=%b fv=%b cyc=%0d exp pc=000 done=0 fv=0 cyc=0",
                         prog_ctr_out, done, fetch_valid, cycle_ct);
      end
      // Stays in IDLE without start even with control inputs asserted.
      jump = 1; target = 12'h055;
      @(negedge clk);
      total++;
      if (fetch_valid !== 1'b0 || prog_ctr_out !== 12'h000) begin
         bad++; $display("FAIL idle_hold fv=%b pc=%h exp fv=0 pc=000", fetch_valid, prog_ctr_out);
      end
      clr_ctl();
   endtask

   task automatic test_basic;
      start = 1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (prog_ctr_out !== 12'(i) || fetch_valid !== 1'b1 || cycle_ct !== 16'(i)) begin
            bad++; $display("FAIL basic_seq pc=%h fv=%b cyc=%0d exp pc=%h fv=1 cyc=%0d",
                            prog_ctr_out, fetch_valid, cycle_ct, 12'(i), i);
         end
         if (i == 7) halt = 1;
         if (i < 7) @(negedge clk);
      end
      @(negedge clk);
      halt = 0;
      total++;
      if (done !== 1'b1 || fetch_valid !== 1'b0 || prog_ctr_out !== 12'h007 || cycle_ct !== 16'd8) begin
         bad++; $display("FAIL basic_done done=%b fv=%b pc=%h cyc=%0d exp done=1 fv=0 pc=007 cyc=8",
                         done, fetch_valid, prog_ctr_out, cycle_ct);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL basic_done_held done=%b exp 1", done);
      end
      finish_run("basic");
      total++;
      if (cycle_ct !== 16'd8 || prog_ctr_out !== 12'h007) begin
         bad++; $display("FAIL basic_idle_hold cyc=%0d pc=%h exp cyc=8 pc=007", cycle_ct, prog_ctr_out);
      end
   endtask

   task automatic test_jump_stall;
      start_run();
      repeat (3) @(negedge clk);
      total++;
      if (prog_ctr_out !== 12'h003) begin
         bad++; $display("FAIL js_pre pc=%h exp 003", prog_ctr_out);
      end
      jump = 1; target = 12'h100;
      @(negedge clk);
      clr_ctl();
      total++;
      if (prog_ctr_out !== 12'h100) begin
         bad++; $display("FAIL js_jump pc=%h exp 100", prog_ctr_out);
      end
      @(negedge clk);
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (i == 1) stall = 0;
         total++;
         if (prog_ctr_out !== 12'h101 || fetch_valid !== 1'b1) begin
            bad++; $display("FAIL js_stall pc=%h fv=%b exp pc=101 fv=1", prog_ctr_out, fetch_valid);
         end
      end
      @(negedge clk);
      total++;
      if (prog_ctr_out !== 12'h102) begin
         bad++; $display("FAIL js_after_stall pc=%h exp 102", prog_ctr_out);
      end
      halt = 1; jump = 1; target = 12'h200;
      @(negedge clk);
      clr_ctl();
      total++;
      if (done !== 1'b1 || prog_ctr_out !== 12'h102 || cycle_ct !== 16'd9) begin
         bad++; $display("FAIL js_halt_jump done=%b pc=%h cyc=%0d exp done=1 pc=102 cyc=9",
                         done, prog_ctr_out, cycle_ct);
      end
      finish_run("js");
   endtask

   task automatic test_wrap;
      start_run();
      jump = 1; target = 12'hFFF;
      @(negedge clk);
      clr_ctl();
      total++;
      if (prog_ctr_out !== 12'hFFF) begin
         bad++; $display("FAIL wrap_top pc=%h exp fff", prog_ctr_out);
      end
      @(negedge clk);
      total++;
      if (prog_ctr_out !== 12'h000 || fetch_valid !== 1'b1) begin
         bad++; $display("FAIL wrap_zero pc=%h fv=%b exp pc=000 fv=1", prog_ctr_out, fetch_valid);
      end
      halt = 1;
      @(negedge clk);
      clr_ctl();
      finish_run("wrap");
   endtask

   task automatic test_saturation;
      start_run();
      repeat (65534) @(negedge clk);
      total++;
      if (cycle_ct !== 16'hFFFE) begin
         bad++; $display("FAIL sat_pre cyc=%h exp fffe", cycle_ct);
      end
      @(negedge clk);
      total++;
      if (cycle_ct !== 16'hFFFF || prog_ctr_out !== 12'hFFF) begin
         bad++; $display("FAIL sat_hit cyc=%h pc=%h exp cyc=ffff pc=fff", cycle_ct, prog_ctr_out);
      end
      repeat (5) @(negedge clk);
      total++;
      if (cycle_ct !== 16'hFFFF || prog_ctr_out !== 12'h004) begin
         bad++; $display("FAIL sat_hold cyc=%h pc=%h exp cyc=ffff pc=004", cycle_ct, prog_ctr_out);
      end
      halt = 1;
      @(negedge clk);
      clr_ctl();
      total++;
      if (cycle_ct !== 16'hFFFF || done !== 1'b1) begin
         bad++; $display("FAIL sat_done cyc=%h done=%b exp cyc=ffff done=1", cycle_ct, done);
      end
      finish_run("sat");
   endtask

   task automatic test_reset_mid_and_held_start;
      start_run();
      repeat (32) @(negedge clk);
      total++;
      if (prog_ctr_out !== 12'h020) begin
         bad++; $display("FAIL rst_mid_pre pc=%h exp 020", prog_ctr_out);
      end
      reset = 1;
      @(negedge clk);
      reset = 0;
      total++;
      if (prog_ctr_out !== 12'h000 || fetch_valid !== 1'b0 || cycle_ct !== 16'd0 || done !== 1'b0) begin
         bad++; $display("FAIL rst_mid pc=%h fv=%b cyc=%0d done=%b exp pc=000 fv=0 cyc=0 done=0",
                         prog_ctr_out, fetch_valid, cycle_ct, done);
      end
      start = 1;
      @(negedge clk);
      halt = 1;
      @(negedge clk);
      clr_ctl();
      for (int i = 0; i < 3; i++) begin
         total++;
         if (done !== 1'b1 || fetch_valid !== 1'b0) begin
            bad++; $display("FAIL held_start_no_rerun done=%b fv=%b exp done=1 fv=0", done, fetch_valid);
         end
         @(negedge clk);
      end
      start = 0;
      @(negedge clk);
      total++;
      if (done !== 1'b0 || fetch_valid !== 1'b0) begin
         bad++; $display("FAIL held_start_release done=%b fv=%b exp done=0 fv=0", done, fetch_valid);
      end
      start = 1;
      @(negedge clk);
      start = 0;
      total++;
      if (fetch_valid !== 1'b1 || prog_ctr_out !== 12'h000 || cycle_ct !== 16'd0) begin
         bad++; $display("FAIL held_start_rerun fv=%b pc=%h cyc=%0d exp fv=1 pc=000 cyc=0",
                         fetch_valid, prog_ctr_out, cycle_ct);
      end
      halt = 1;
      @(negedge clk);
      clr_ctl();
      finish_run("held");
   endtask

   task automatic test_call_ret;
      logic [11:0] exp_ret;
`ifdef PROG_CTR_LINK_EN
      exp_ret = 12'h006;
`else
      exp_ret = 12'h041;
`endif
      start_run();
      repeat (5) @(negedge clk);
      call = 1; target = 12'h040;
      @(negedge clk);
      clr_ctl();
      total++;
      if (prog_ctr_out !== 12'h040) begin
         bad++; $display("FAIL call_target pc=%h exp 040", prog_ctr_out);
      end
      ret = 1;
      @(negedge clk);
      clr_ctl();
      total++;
      if (prog_ctr_out !== exp_ret || fetch_valid !== 1'b1) begin
         bad++; $display("FAIL ret_result pc=%h fv=%b exp pc=%h fv=1", prog_ctr_out, fetch_valid, exp_ret);
      end
      halt = 1;
      @(negedge clk);
      clr_ctl();
      finish_run("callret");
   endtask

`ifdef PROG_CTR_LINK_EN
   task automatic test_link_nested;
      logic [11:0] exp_pops [4];
      exp_pops[0] = 12'h041; exp_pops[1] = 12'h031;
      exp_pops[2] = 12'h021; exp_pops[3] = 12'h011;
      start_run();
      for (int i = 1; i <= 5; i++) begin
         call = 1; target = 12'(i * 16);
         @(negedge clk);
         clr_ctl();
      end
      total++;
      if (prog_ctr_out !== 12'h050) begin
         bad++; $display("FAIL nest_calls pc=%h exp 050", prog_ctr_out);
      end
      for (int i = 0; i < 4; i++) begin
         ret = 1;
         @(negedge clk);
         clr_ctl();
         total++;
         if (prog_ctr_out !== exp_pops[i] || fetch_valid !== 1'b1) begin
            bad++; $display("FAIL nest_ret%0d pc=%h fv=%b exp pc=%h fv=1", i, prog_ctr_out, fetch_valid, exp_pops[i]);
         end
      end
      ret = 1;
      @(negedge clk);
      clr_ctl();
      total++;
      if (done !== 1'b1 || prog_ctr_out !== 12'h011) begin
         bad++; $display("FAIL nest_empty_ret done=%b pc=%h exp done=1 pc=011", done, prog_ctr_out);
      end
      finish_run("nest");
   endtask

   task automatic test_link_call_ret_same;
      start_run();
      call = 1; target = 12'h010;
      @(negedge clk);
      call = 1; ret = 1; target = 12'h030;
      @(negedge clk);
      clr_ctl();
      total++;
      if (prog_ctr_out !== 12'h001) begin
         bad++; $display("FAIL callret_same pc=%h exp 001", prog_ctr_out);
      end
      ret = 1;
      @(negedge clk);
      clr_ctl();
      total++;
      if (done !== 1'b1 || prog_ctr_out !== 12'h001) begin
         bad++; $display("FAIL callret_no_push done=%b pc=%h exp done=1 pc=001", done, prog_ctr_out);
      end
      finish_run("crs");
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      reset = 1;
      start = 0;
      clr_ctl();
      @(negedge clk);
      test_reset();
      test_basic();
      test_jump_stall();
      test_wrap();
      test_reset_mid_and_held_start();
      test_call_ret();
`ifdef PROG_CTR_LINK_EN
      test_link_nested();
      test_link_call_ret_same();
`endif
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
